status_monitor: RTL and testbench

- Synthesizable, parametrised checker for firmware self-test status words driven on a user GPIO bus (e.g. mprj_io[31:16]).
- Filters the asynchronous bus and decodes START, CONSOLE, PASS and FAIL codes.
- Buffers console characters in a FIFO with a ready/valid drain, and enforces a cycle-count timeout.
- Used in simulation benches and FPGA bring-up to produce one sticky verdict per run.

---
 rtl/status_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_status_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_monitor.sv
// Firmware self-test status monitor: filters an asynchronous status bus, decodes
// START/CONSOLE/PASS/FAIL codes, queues console characters and produces one sticky verdict.
module status_monitor #(
    parameter int unsigned          STATUS_W       = 16,
    parameter int unsigned          CODE_W         = 8,
    parameter logic [CODE_W-1:0]    CODE_START     = 8'hA0,
    parameter logic [CODE_W-1:0]    CODE_CONS      = 8'hA1,
    parameter logic [CODE_W-1:0]    CODE_PASS      = 8'hAB,
    parameter logic [CODE_W-1:0]    CODE_FAIL      = 8'hAE,
    parameter int unsigned          FIFO_DEPTH     = 16,
    parameter int unsigned          STABLE_CYCLES  = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 1500000
) (
    input  logic                         clock,
    input  logic                         resetb,
    input  logic [STATUS_W-1:0]          status_in,
    input  logic                         clear,
    input  logic                         timeout_en,
    input  logic                         cons_ready,
    output logic                         cons_valid,
    output logic [STATUS_W-CODE_W-1:0]   cons_data,
    output logic                         started,
    output logic                         passed,
    output logic                         failed,
    output logic                         timed_out,
    output logic                         done,
    output logic                         overflow,
    output logic [31:0]                  cycle_count
);

    localparam int unsigned PAY_W  = STATUS_W - CODE_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and stability filter
    // ------------------------------------------------------------------
    logic [STATUS_W-1:0] sync_r1;
    logic [STATUS_W-1:0] sync_r2;
    logic [STATUS_W-1:0] acc;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_cnt_nxt_c;
    logic                evt_c;
    logic [CODE_W-1:0]   code_c;
    logic [PAY_W-1:0]    payload_c;

    // The count tracks edges on which r2 keeps its value; r1 is r2's next value.
    always_comb begin
        stab_cnt_nxt_c = stab_cnt;
        if (sync_r1 != sync_r2) begin
            stab_cnt_nxt_c = '0;
        end else if (stab_cnt != STAB_W'(STABLE_CYCLES)) begin
            stab_cnt_nxt_c = stab_cnt + STAB_W'(1);
        end
    end

    // The accepted value is r2 itself, so decode directly from it on the event edge.
    assign evt_c     = (stab_cnt_nxt_c == STAB_W'(STABLE_CYCLES)) && (sync_r2 != acc);
    assign code_c    = sync_r2[STATUS_W-1 -: CODE_W];
    assign payload_c = sync_r2[PAY_W-1:0];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_r1  <= '0;
            sync_r2  <= '0;
            acc      <= '0;
            stab_cnt <= '0;
        end else if (clear) begin
            sync_r1  <= '0;
            sync_r2  <= '0;
            acc      <= '0;
            stab_cnt <= '0;
        end else begin
            sync_r1  <= status_in;
            sync_r2  <= sync_r1;
            stab_cnt <= stab_cnt_nxt_c;
            if (evt_c) begin
                acc <= sync_r2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Verdict FSM, cycle counter and timeout
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic        push_c;
    logic        started_d;
    logic [31:0] cycle_d;
    logic [31:0] cycle_inc_c;
    logic        active_c;

    always_comb begin
        state_d     = state_q;
        push_c      = 1'b0;
        started_d   = started;
        cycle_d     = cycle_count;
        cycle_inc_c = cycle_count + 32'd1;
        active_c    = (state_q == ST_IDLE) || (state_q == ST_RUNNING);

        if (active_c) begin
            cycle_d = cycle_inc_c;
            if (timeout_en && (cycle_inc_c == 32'(TIMEOUT_CYCLES))) begin
                state_d = ST_TIMEOUT;
            end
            // PASS/FAIL override a coincident timeout; START does not.
            if (evt_c) begin
                case (code_c)
                    CODE_START: begin
                        started_d = 1'b1;
                        if ((state_q == ST_IDLE) && (state_d != ST_TIMEOUT)) begin
                            state_d = ST_RUNNING;
                        end
                    end
                    CODE_CONS: push_c  = 1'b1;
                    CODE_PASS: state_d = ST_PASS;
                    CODE_FAIL: state_d = ST_FAIL;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            started     <= 1'b0;
            passed      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            started     <= 1'b0;
            passed      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            started     <= started_d;
            passed      <= (state_d == ST_PASS);
            failed      <= (state_d == ST_FAIL);
            timed_out   <= (state_d == ST_TIMEOUT);
            done        <= (state_d == ST_PASS) || (state_d == ST_FAIL) ||
                           (state_d == ST_TIMEOUT);
            cycle_count <= cycle_d;
        end
    end

    // ------------------------------------------------------------------
    // Console character FIFO
    // ------------------------------------------------------------------
    logic [PAY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] fifo_cnt_nxt_c;
    logic             full_c;
    logic             pop_c;
    logic             wr_en_c;
    logic             drop_c;

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign full_c  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop_c   = cons_valid && cons_ready;
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    always_comb begin
        fifo_cnt_nxt_c = fifo_cnt;
        case ({wr_en_c, pop_c})
            2'b10:   fifo_cnt_nxt_c = fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt_nxt_c = fifo_cnt - CNT_W'(1);
            default: fifo_cnt_nxt_c = fifo_cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= payload_c;
        end
    end

    assign cons_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            cons_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            cons_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt   <= fifo_cnt_nxt_c;
            cons_valid <= (fifo_cnt_nxt_c != '0);
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_status_monitor.sv
// Directed bench for status_monitor: filtering, decode, FIFO drain/overflow,
// timeout priority, asynchronous reset and synchronous clear.
module tb_status_monitor;

    logic        clock;
    logic        resetb;
    logic [15:0] status_in;
    logic        clear;
    logic        timeout_en;
    logic        cons_ready;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        started;
    logic        passed;
    logic        failed;
    logic        timed_out;
    logic        done;
    logic        overflow;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    status_monitor #(
        .STATUS_W      (16),
        .CODE_W        (8),
        .FIFO_DEPTH    (16),
        .STABLE_CYCLES (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .status_in  (status_in),
        .clear      (clear),
        .timeout_en (timeout_en),
        .cons_ready (cons_ready),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .started    (started),
        .passed     (passed),
        .failed     (failed),
        .timed_out  (timed_out),
        .done       (done),
        .overflow   (overflow),
        .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clear with the bus parked at zero so the previous code is not re-accepted.
    task automatic do_clear();
        status_in = 16'h0000;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
    endtask

    logic [7:0] exp3 [3];

    initial begin
        resetb     = 1'b0;
        status_in  = 16'h0000;
        clear      = 1'b0;
        timeout_en = 1'b0;
        cons_ready = 1'b1;
        exp3       = '{8'h41, 8'h42, 8'h41};
        hold(3);
        chk("rst_started", 32'(started), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(cons_valid), 32'd0);
        chk("rst_count", cycle_count, 32'd0);

        // 1: START, two console chars, PASS; event lands 4 ticks after applying
        resetb    = 1'b1;
        status_in = 16'hA000;
        hold(3);
        chk("t1_started_early", 32'(started), 32'd0);
        tick();
        chk("t1_started", 32'(started), 32'd1);
        chk("t1_count4", cycle_count, 32'd4);
        hold(6);
        status_in = 16'hA148;
        hold(4);
        chk("t1_valid_h", 32'(cons_valid), 32'd1);
        chk("t1_data_h", 32'(cons_data), 32'h48);
        tick();
        chk("t1_popped_h", 32'(cons_valid), 32'd0);
        hold(5);
        status_in = 16'hA169;
        hold(4);
        chk("t1_valid_i", 32'(cons_valid), 32'd1);
        chk("t1_data_i", 32'(cons_data), 32'h69);
        hold(6);
        status_in = 16'hAB00;
        hold(3);
        chk("t1_pass_early", 32'(passed), 32'd0);
        tick();
        chk("t1_passed", 32'(passed), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_failed", 32'(failed), 32'd0);
        chk("t1_count_pass", cycle_count, 32'd34);
        hold(5);
        chk("t1_count_frozen", cycle_count, 32'd34);

        // clear after PASS returns to IDLE with a zero count
        do_clear();
        chk("clr_passed", 32'(passed), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_started", 32'(started), 32'd0);
        chk("clr_count", cycle_count, 32'd0);
        hold(3);
        chk("clr_count3", cycle_count, 32'd3);

        // 2: 20 characters into a 16-deep FIFO, then drain
        do_clear();
        cons_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            status_in = 16'hA130 + 16'(i);
            hold(4);
            if (i == 15) chk("t2_no_ovf_at16", 32'(overflow), 32'd0);
        end
        hold(4);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_valid", 32'(cons_valid), 32'd1);
        cons_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_drain_valid", 32'(cons_valid), 32'd1);
            chk("t2_drain_data", 32'(cons_data), 32'h30 + 32'(k));
            tick();
        end
        chk("t2_empty", 32'(cons_valid), 32'd0);

        // 3: one-cycle PASS glitch is rejected; a repeated value pushes once
        do_clear();
        cons_ready = 1'b0;
        status_in  = 16'hA141;
        hold(5);
        status_in  = 16'hABFF;
        tick();
        status_in  = 16'hA142;
        hold(6);
        chk("t3_no_pass", 32'(passed), 32'd0);
        status_in  = 16'hA141;
        hold(6);
        status_in  = 16'hA141;
        hold(6);
        chk("t3_no_done", 32'(done), 32'd0);
        cons_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_valid", 32'(cons_valid), 32'd1);
            chk("t3_data", 32'(cons_data), 32'(exp3[k]));
            tick();
        end
        chk("t3_empty", 32'(cons_valid), 32'd0);

        // 4: timeout at 100 cycles, later PASS ignored
        do_clear();
        timeout_en = 1'b1;
        status_in  = 16'hA000;
        hold(99);
        chk("t4_not_yet", 32'(timed_out), 32'd0);
        chk("t4_count99", cycle_count, 32'd99);
        tick();
        chk("t4_timed_out", 32'(timed_out), 32'd1);
        chk("t4_count100", cycle_count, 32'd100);
        chk("t4_done", 32'(done), 32'd1);
        status_in = 16'hAB00;
        hold(6);
        chk("t4_pass_ignored", 32'(passed), 32'd0);
        chk("t4_still_to", 32'(timed_out), 32'd1);
        chk("t4_frozen", cycle_count, 32'd100);

        // 4b: timeout disabled, PASS accepted past the budget
        do_clear();
        timeout_en = 1'b0;
        status_in  = 16'hA000;
        hold(120);
        chk("t4b_no_to", 32'(timed_out), 32'd0);
        chk("t4b_count", cycle_count, 32'd120);
        status_in = 16'hAB00;
        hold(4);
        chk("t4b_passed", 32'(passed), 32'd1);
        chk("t4b_count_pass", cycle_count, 32'd124);

        // 5: FAIL and timeout on the same edge, FAIL wins
        do_clear();
        timeout_en = 1'b1;
        status_in  = 16'hA000;
        hold(96);
        status_in  = 16'hAE00;
        hold(3);
        chk("t5_failed_early", 32'(failed), 32'd0);
        tick();
        chk("t5_failed", 32'(failed), 32'd1);
        chk("t5_no_timeout", 32'(timed_out), 32'd0);
        chk("t5_count", cycle_count, 32'd100);

        // 6: asynchronous reset with characters queued
        do_clear();
        timeout_en = 1'b0;
        cons_ready = 1'b0;
        status_in  = 16'hA000;
        hold(4);
        for (int i = 0; i < 5; i++) begin
            status_in = 16'hA150 + 16'(i);
            hold(4);
        end
        chk("t6_started", 32'(started), 32'd1);
        chk("t6_queued", 32'(cons_valid), 32'd1);
        resetb = 1'b0;
        #1;
        chk("t6_rst_started", 32'(started), 32'd0);
        chk("t6_rst_valid", 32'(cons_valid), 32'd0);
        chk("t6_rst_count", cycle_count, 32'd0);
        status_in = 16'h0000;
        hold(2);
        resetb = 1'b1;
        hold(3);
        chk("t6_empty_after", 32'(cons_valid), 32'd0);
        chk("t6_count_after", cycle_count, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
